cpu_mem_responder: RTL and testbench
====================================

# cpu_mem_responder

Memory responder at the far end of the CPU's two bus ports: instruction fetch (pc port) and load/store (ldst port). It serves word reads and writes from one shared on-chip RAM, adds a small memory-mapped I/O window, and returns read data with a fixed, parameterised latency. It holds a sticky error flag for illegal accesses. It sits at top level beside `cpu`, wired port-for-port to its `o_pc_*` / `o_ldst_*` / `i_*_rddata` signals.

## Interface
- `DEPTH_WORDS`, default 4096: number of 16-bit RAM words; byte range 0x0000 to 2*DEPTH_WORDS-1; must be a power of 2 and ≤ 4096.
- `READ_LATENCY`, default 1: cycles from a read request to its data; legal values are 1 and 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `i_pc_addr` input 16: fetch byte address.
- `i_pc_rd` input 1: fetch read request.
- `o_pc_rddata` output 16: fetch read data.
- `o_pc_rdvalid` output 1: `o_pc_rddata` carries a new result this cycle.
- `i_ldst_addr` input 16: load/store byte address.
- `i_ldst_rd` input 1: load request.
- `i_ldst_wr` input 1: store request.
- `i_ldst_wrdata` input 16: store data.
- `o_ldst_rddata` output 16: load read data.
- `o_ldst_rdvalid` output 1: `o_ldst_rddata` carries a new result this cycle.
- `i_sw` input 16: switch inputs; readable over MMIO.
- `o_led` output 16: LED register; written over MMIO.
- `o_err` output 1: sticky illegal-access flag.

## Operation
- Addresses are byte addresses. The word index is `addr[15:1]`. `addr[0]=1` is misaligned: the access proceeds on `addr & ~1`, except that writes are dropped, and `o_err` is set.
- RAM region: `addr < 2*DEPTH_WORDS`. Both ports read the RAM. Only the ldst port writes it.
- MMIO region, ldst port only:
  - 0xF000: LED register, read/write.
  - 0xF002: `i_sw`, read-only; writes are ignored and set `o_err`.
- Any other address, or the pc port addressing MMIO:
  - Reads return 0x0000.
  - Writes are dropped.
  - `o_err` is set.
- `i_ldst_rd` and `i_ldst_wr` high in the same cycle: the write is performed, the read is not issued, and `o_err` is set.
- Collision: a ldst write and a pc read to the same word in the same cycle are write-first. The pc result carries the new data.
- Each port has its own read pipeline of depth READ_LATENCY. A valid bit and a data word travel through each stage.
- The `o_*_rddata` outputs hold their last result while `o_*_rdvalid` is 0.
- `o_err` is cleared only by reset.
- RAM contents are not reset. The LED register resets to 0x0000.

## Timing
- Reset values: `o_pc_rddata`=0, `o_ldst_rddata`=0, both rdvalid=0, `o_led`=0, `o_err`=0. All in-flight reads are discarded.
- Read issued at edge N (rd=1 sampled): data and rdvalid=1 appear after edge N+READ_LATENCY-1, i.e. READ_LATENCY cycles after the request cycle.
- Back-to-back reads on every cycle are supported on both ports at full throughput. No back-pressure.
- A write commits at the edge where wr=1 is sampled. A read issued on the following cycle returns the new value.
- An `o_led` update is visible the cycle after the write edge.
- `o_err` rises the cycle after the offending request edge.
- When reset asserts mid-read, rdvalid drops immediately and the result is never delivered.
- `i_sw` is sampled at the read request edge.

## Configuration
- `CPU_MEM_MMIO_EN`:
  - Defined: MMIO window, LED register and `i_sw` read behave as above.
  - Undefined: 0xF000/0xF002 are treated as out-of-range (read 0, write dropped, `o_err` set), `o_led` is tied to 0x0000, and `i_sw` is unused.

## Test plan
- Write then read: ldst write 0x1234 to 0x0010; ldst read 0x0010 next cycle → `o_ldst_rddata`=0x1234 with rdvalid after READ_LATENCY, for both latencies 1 and 2.
- Collision: same cycle, ldst write 0xBEEF to 0x0020 and pc read 0x0020 → `o_pc_rddata`=0xBEEF. Streaming pc reads of 0x0000, 0x0002, 0x0004 on consecutive cycles → results in order, rdvalid high on three consecutive cycles.
- MMIO: write 0x00A5 to 0xF000 → `o_led`=0x00A5 next cycle. `i_sw`=0x5A5A, read 0xF002 → 0x5A5A. Without `CPU_MEM_MMIO_EN` → reads return 0, `o_led` stays 0, `o_err`=1.
- Errors:
  - Write to 0x0011: RAM word 0x0010 is unchanged and `o_err`=1.
  - Read at 2*DEPTH_WORDS: returns 0 and sets `o_err`.
  - rd+wr in the same cycle: the write lands, there is no rdvalid, and `o_err`=1.
- Reset mid-read: issue a pc read with READ_LATENCY=2 and assert reset one cycle later → rdvalid never pulses, outputs are 0 and `o_err`=0. RAM data written before reset is still readable afterwards.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//
// Memory responder for the CPU's two bus ports. The instruction fetch port (pc)
// and the load/store port (ldst) share one word-wide on-chip RAM. Only ldst can
// write the RAM. Read data comes back after a fixed READ_LATENCY (1 or 2) cycles,
// and each port can issue a new read every cycle. A small MMIO window
// (LED register at 0xF000, switch inputs at 0xF002) is available on the ldst
// port when CPU_MEM_MMIO_EN is defined. Without it, those addresses behave as
// unmapped and o_led is tied to zero. Any illegal access sets the sticky o_err
// flag, which only reset clears.
//
// Configuration macro: CPU_MEM_MMIO_EN (undefined by default -> no MMIO window)
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   i_pc_addr/i_pc_rd   fetch byte address / read request
//   o_pc_rddata/rdvalid fetch read data (held between results) / result strobe
//   i_ldst_addr         load/store byte address
//   i_ldst_rd/wr        load / store request
//   i_ldst_wrdata       store data
//   o_ldst_rddata/valid load read data (held between results) / result strobe
//   i_sw                switch inputs, read at 0xF002
//   o_led               LED register, written at 0xF000
//   o_err               sticky illegal-access flag

module cpu_mem_responder #(
    parameter int DEPTH_WORDS  = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_pc_addr,
    input  logic        i_pc_rd,
    output logic [15:0] o_pc_rddata,
    output logic        o_pc_rdvalid,
    input  logic [15:0] i_ldst_addr,
    input  logic        i_ldst_rd,
    input  logic        i_ldst_wr,
    input  logic [15:0] i_ldst_wrdata,
    output logic [15:0] o_ldst_rddata,
    output logic        o_ldst_rdvalid,
    input  logic [15:0] i_sw,
    output logic [15:0] o_led,
    output logic        o_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [16:0] RAM_BYTES = 17'(2 * DEPTH_WORDS);

    logic [15:0] mem [DEPTH_WORDS];

    logic          ld_mis;
    logic          ld_ram;
    logic          ld_led;
    logic          ld_sw;
    logic          ld_rd_iss;
    logic          ram_we;
    logic          ld_err;
    logic [AW-1:0] ld_widx;
    logic [15:0]   ld_rdata;
    logic [15:0]   mmio_rdata;

    logic          pc_mis;
    logic          pc_ram;
    logic          pc_err;
    logic [AW-1:0] pc_widx;
    logic [15:0]   pc_rdata;

    logic          err_q, err_d;

    logic [READ_LATENCY-1:0]       pc_vld_q, pc_vld_d;
    logic [READ_LATENCY-1:0][15:0] pc_dat_q, pc_dat_d;
    logic [READ_LATENCY-1:0]       ld_vld_q, ld_vld_d;
    logic [READ_LATENCY-1:0][15:0] ld_dat_q, ld_dat_d;

    // ------------------------------------------------------------------
    // MMIO window
    // ------------------------------------------------------------------
`ifdef CPU_MEM_MMIO_EN
    localparam logic [15:0] LED_ADDR = 16'hF000;
    localparam logic [15:0] SW_ADDR  = 16'hF002;

    logic [15:0] ld_aligned;
    logic        led_we;
    logic [15:0] led_q, led_d;

    // A misaligned address still decodes on its even neighbour.
    assign ld_aligned = {i_ldst_addr[15:1], 1'b0};
    assign ld_led     = (ld_aligned == LED_ADDR);
    assign ld_sw      = (ld_aligned == SW_ADDR);
    assign led_we     = i_ldst_wr & ld_led & ~ld_mis;

    always_comb begin
        led_d = led_q;
        if (led_we) begin
            led_d = i_ldst_wrdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= 16'h0000;
        end else begin
            led_q <= led_d;
        end
    end

    always_comb begin
        mmio_rdata = 16'h0000;
        if (ld_led) begin
            mmio_rdata = led_q;
        end else if (ld_sw) begin
            mmio_rdata = i_sw;
        end
    end

    assign o_led = led_q;
`else
    logic unused_sw;

    assign ld_led     = 1'b0;
    assign ld_sw      = 1'b0;
    assign mmio_rdata = 16'h0000;
    assign o_led      = 16'h0000;
    assign unused_sw  = ^i_sw;
`endif

    // ------------------------------------------------------------------
    // Address decode and read data selection
    // ------------------------------------------------------------------
    always_comb begin
        ld_mis    = i_ldst_addr[0];
        ld_ram    = ({1'b0, i_ldst_addr} < RAM_BYTES);
        ld_widx   = i_ldst_addr[AW:1];
        // A combined rd+wr is treated as a write only.
        ld_rd_iss = i_ldst_rd & ~i_ldst_wr;
        ram_we    = i_ldst_wr & ld_ram & ~ld_mis;

        ld_err = ((i_ldst_rd | i_ldst_wr) & (ld_mis | ~(ld_ram | ld_led | ld_sw)))
               | (i_ldst_rd & i_ldst_wr)
               | (i_ldst_wr & ld_sw);

        ld_rdata = mmio_rdata;
        if (ld_ram) begin
            ld_rdata = mem[ld_widx];
        end

        pc_mis  = i_pc_addr[0];
        pc_ram  = ({1'b0, i_pc_addr} < RAM_BYTES);
        pc_widx = i_pc_addr[AW:1];
        pc_err  = i_pc_rd & (pc_mis | ~pc_ram);

        // A same-cycle ldst write to the word being fetched is forwarded so
        // that the fetch sees the new data.
        pc_rdata = 16'h0000;
        if (pc_ram) begin
            if (ram_we && (ld_widx == pc_widx)) begin
                pc_rdata = i_ldst_wrdata;
            end else begin
                pc_rdata = mem[pc_widx];
            end
        end

        err_d = err_q | ld_err | pc_err;
    end

    // The RAM contents are not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ld_widx] <= i_ldst_wrdata;
        end
    end

    // ------------------------------------------------------------------
    // Read pipelines: stage 0 captures at the request edge. A stage's data
    // only moves when its valid does, so the last stage holds the most recent
    // result while rdvalid is low.
    // ------------------------------------------------------------------
    always_comb begin
        pc_vld_d    = pc_vld_q;
        pc_dat_d    = pc_dat_q;
        ld_vld_d    = ld_vld_q;
        ld_dat_d    = ld_dat_q;

        pc_vld_d[0] = i_pc_rd;
        if (i_pc_rd) begin
            pc_dat_d[0] = pc_rdata;
        end
        ld_vld_d[0] = ld_rd_iss;
        if (ld_rd_iss) begin
            ld_dat_d[0] = ld_rdata;
        end

        for (int i = 1; i < READ_LATENCY; i++) begin
            pc_vld_d[i] = pc_vld_q[i-1];
            if (pc_vld_q[i-1]) begin
                pc_dat_d[i] = pc_dat_q[i-1];
            end
            ld_vld_d[i] = ld_vld_q[i-1];
            if (ld_vld_q[i-1]) begin
                ld_dat_d[i] = ld_dat_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_vld_q <= '0;
            pc_dat_q <= '0;
            ld_vld_q <= '0;
            ld_dat_q <= '0;
            err_q    <= 1'b0;
        end else begin
            pc_vld_q <= pc_vld_d;
            pc_dat_q <= pc_dat_d;
            ld_vld_q <= ld_vld_d;
            ld_dat_q <= ld_dat_d;
            err_q    <= err_d;
        end
    end

    assign o_pc_rdvalid   = pc_vld_q[READ_LATENCY-1];
    assign o_pc_rddata    = pc_dat_q[READ_LATENCY-1];
    assign o_ldst_rdvalid = ld_vld_q[READ_LATENCY-1];
    assign o_ldst_rddata  = ld_dat_q[READ_LATENCY-1];
    assign o_err          = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: one instance with READ_LATENCY=1 and one with
// READ_LATENCY=2 share the same stimulus. A word-array reference model
// predicts every output after every clock edge. A directed vector table and
// some hand-written reset/error sequences add fixed expectations on top of it.

module tb_cpu_mem_responder;

    localparam int DEPTH = 256;
`ifdef CPU_MEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif
    localparam logic [15:0] LEDX = MMIO ? 16'h00A5 : 16'h0000;
    localparam logic [15:0] SWX  = MMIO ? 16'h5A5A : 16'h0000;
    localparam bit          ERRX = !MMIO;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_addr, ld_addr, ld_wd, sw;
    logic        pc_rd, ld_rd, ld_wr;

    logic [15:0] pc_d1, ld_d1, led1, pc_d2, ld_d2, led2;
    logic        pc_v1, ld_v1, err1, pc_v2, ld_v2, err2;

    always #5 clk = ~clk;

    cpu_mem_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .i_pc_addr(pc_addr), .i_pc_rd(pc_rd),
        .o_pc_rddata(pc_d1), .o_pc_rdvalid(pc_v1),
        .i_ldst_addr(ld_addr), .i_ldst_rd(ld_rd), .i_ldst_wr(ld_wr),
        .i_ldst_wrdata(ld_wd),
        .o_ldst_rddata(ld_d1), .o_ldst_rdvalid(ld_v1),
        .i_sw(sw), .o_led(led1), .o_err(err1)
    );

    cpu_mem_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset),
        .i_pc_addr(pc_addr), .i_pc_rd(pc_rd),
        .o_pc_rddata(pc_d2), .o_pc_rdvalid(pc_v2),
        .i_ldst_addr(ld_addr), .i_ldst_rd(ld_rd), .i_ldst_wr(ld_wr),
        .i_ldst_wrdata(ld_wd),
        .o_ldst_rddata(ld_d2), .o_ldst_rdvalid(ld_v2),
        .i_sw(sw), .o_led(led2), .o_err(err2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [15:0] mem_m [DEPTH];
    logic [15:0] led_m;
    bit          err_m;
    logic [15:0] last_pc1, last_ld1, last_pc2, last_ld2;
    bit          prev_pc_iss, prev_ld_iss;
    logic [15:0] prev_pc_res, prev_ld_res;

    typedef struct {
        bit          pc_rd;
        logic [15:0] pc_a;
        bit          ld_rd;
        bit          ld_wr;
        logic [15:0] ld_a;
        logic [15:0] wd;
        logic [15:0] sw;
        bit          e_pcv;
        logic [15:0] e_pcd;
        bit          e_ldv;
        logic [15:0] e_ldd;
        logic [15:0] e_led;
        bit          e_err;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        pc_rd = 1'b0; pc_addr = 16'h0; ld_rd = 1'b0; ld_wr = 1'b0;
        ld_addr = 16'h0; ld_wd = 16'h0;
    endtask

    task automatic model_clear();
        led_m = 16'h0; err_m = 1'b0;
        last_pc1 = 16'h0; last_ld1 = 16'h0; last_pc2 = 16'h0; last_ld2 = 16'h0;
        prev_pc_iss = 1'b0; prev_ld_iss = 1'b0;
        prev_pc_res = 16'h0; prev_ld_res = 16'h0;
    endtask

    task automatic check_all();
        chk("led_l1", led1, led_m);
        chk("err_l1", {15'h0, err1}, {15'h0, err_m});
        chk("led_l2", led2, led_m);
        chk("err_l2", {15'h0, err2}, {15'h0, err_m});
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge.
    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        #1;
        model_clear();
        chk("rst_pc_v1", {15'h0, pc_v1}, 16'h0);
        chk("rst_pc_d1", pc_d1, 16'h0);
        chk("rst_ld_v1", {15'h0, ld_v1}, 16'h0);
        chk("rst_ld_d1", ld_d1, 16'h0);
        chk("rst_pc_v2", {15'h0, pc_v2}, 16'h0);
        chk("rst_pc_d2", pc_d2, 16'h0);
        chk("rst_ld_v2", {15'h0, ld_v2}, 16'h0);
        chk("rst_ld_d2", ld_d2, 16'h0);
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock: evaluate the request against the model, clock, then compare.
    task automatic step();
        bit          pc_iss, ld_iss, l_ram, l_led, l_sw;
        logic [15:0] pc_res, ld_res, la;
        pc_iss = 1'b0; ld_iss = 1'b0; pc_res = 16'h0; ld_res = 16'h0;
        la     = {ld_addr[15:1], 1'b0};
        l_ram  = (int'(ld_addr) < 2 * DEPTH);
        l_led  = MMIO && (la == 16'hF000);
        l_sw   = MMIO && (la == 16'hF002);
        // ldst first: a store is visible to the same-cycle fetch
        if (ld_wr) begin
            if (ld_addr[0] || !(l_ram || l_led) || ld_rd) err_m = 1'b1;
            if (!ld_addr[0]) begin
                if (l_ram) mem_m[int'(la[15:1])] = ld_wd;
                else if (l_led) led_m = ld_wd;
            end
        end else if (ld_rd) begin
            ld_iss = 1'b1;
            if (l_ram)      ld_res = mem_m[int'(la[15:1])];
            else if (l_led) ld_res = led_m;
            else if (l_sw)  ld_res = sw;
            if (ld_addr[0] || !(l_ram || l_led || l_sw)) err_m = 1'b1;
        end
        if (pc_rd) begin
            pc_iss = 1'b1;
            if (int'(pc_addr) < 2 * DEPTH) pc_res = mem_m[int'(pc_addr[15:1])];
            else err_m = 1'b1;
            if (pc_addr[0]) err_m = 1'b1;
        end

        @(posedge clk);
        #1;
        if (pc_iss) last_pc1 = pc_res;
        if (ld_iss) last_ld1 = ld_res;
        chk("pc_v_l1", {15'h0, pc_v1}, {15'h0, pc_iss});
        chk("pc_d_l1", pc_d1, last_pc1);
        chk("ld_v_l1", {15'h0, ld_v1}, {15'h0, ld_iss});
        chk("ld_d_l1", ld_d1, last_ld1);
        if (prev_pc_iss) last_pc2 = prev_pc_res;
        if (prev_ld_iss) last_ld2 = prev_ld_res;
        chk("pc_v_l2", {15'h0, pc_v2}, {15'h0, prev_pc_iss});
        chk("pc_d_l2", pc_d2, last_pc2);
        chk("ld_v_l2", {15'h0, ld_v2}, {15'h0, prev_ld_iss});
        chk("ld_d_l2", ld_d2, last_ld2);
        check_all();
        prev_pc_iss = pc_iss; prev_pc_res = pc_res;
        prev_ld_iss = ld_iss; prev_ld_res = ld_res;
    endtask

    function automatic logic [15:0] rand_addr(input bit allow_mmio);
        logic [15:0] a;
        int unsigned sel;
        sel = $urandom_range(0, 11);
        a   = 16'(2 * $urandom_range(0, DEPTH - 1));
        case (sel)
            0: a = a | 16'h1;
            1: a = 16'($urandom_range(2 * DEPTH, 16'hEFFF));
            2: if (allow_mmio) a = 16'hF000;
            3: if (allow_mmio) a = 16'hF002;
            4: if (allow_mmio) a = 16'hF001;
            5: a = 16'($urandom_range(16'hF004, 16'hFFFF));
            default: ;
        endcase
        return a;
    endfunction

    initial begin
        // pc_rd pc_a   ld_rd ld_wr ld_a  wd  sw  | pcv pcd  ldv ldd  led  err
        vt[0]  = '{0, 16'h0,    0, 1, 16'h0010, 16'h1234, 16'h0,    0, 16'h0,    0, 16'h0,    16'h0, 0};
        vt[1]  = '{0, 16'h0,    1, 0, 16'h0010, 16'h0,    16'h0,    0, 16'h0,    1, 16'h1234, 16'h0, 0};
        vt[2]  = '{1, 16'h0020, 0, 1, 16'h0020, 16'hBEEF, 16'h0,    1, 16'hBEEF, 0, 16'h1234, 16'h0, 0};
        vt[3]  = '{0, 16'h0,    0, 1, 16'h0000, 16'h1111, 16'h0,    0, 16'hBEEF, 0, 16'h1234, 16'h0, 0};
        vt[4]  = '{0, 16'h0,    0, 1, 16'h0002, 16'h2222, 16'h0,    0, 16'hBEEF, 0, 16'h1234, 16'h0, 0};
        vt[5]  = '{0, 16'h0,    0, 1, 16'h0004, 16'h3333, 16'h0,    0, 16'hBEEF, 0, 16'h1234, 16'h0, 0};
        vt[6]  = '{1, 16'h0000, 0, 0, 16'h0,    16'h0,    16'h0,    1, 16'h1111, 0, 16'h1234, 16'h0, 0};
        vt[7]  = '{1, 16'h0002, 0, 0, 16'h0,    16'h0,    16'h0,    1, 16'h2222, 0, 16'h1234, 16'h0, 0};
        vt[8]  = '{1, 16'h0004, 0, 0, 16'h0,    16'h0,    16'h0,    1, 16'h3333, 0, 16'h1234, 16'h0, 0};
        vt[9]  = '{0, 16'h0,    0, 1, 16'hF000, 16'h00A5, 16'h0,    0, 16'h3333, 0, 16'h1234, LEDX,  ERRX};
        vt[10] = '{0, 16'h0,    1, 0, 16'hF002, 16'h0,    16'h5A5A, 0, 16'h3333, 1, SWX,      LEDX,  ERRX};
        vt[11] = '{0, 16'h0,    0, 1, 16'h0011, 16'hFFFF, 16'h0,    0, 16'h3333, 0, SWX,      LEDX,  1};
        vt[12] = '{0, 16'h0,    1, 0, 16'h0010, 16'h0,    16'h0,    0, 16'h3333, 1, 16'h1234, LEDX,  1};
        vt[13] = '{0, 16'h0,    1, 0, 16'h0200, 16'h0,    16'h0,    0, 16'h3333, 1, 16'h0000, LEDX,  1};
        vt[14] = '{0, 16'h0,    1, 1, 16'h0030, 16'h0777, 16'h0,    0, 16'h3333, 0, 16'h0000, LEDX,  1};
        vt[15] = '{0, 16'h0,    1, 0, 16'h0030, 16'h0,    16'h0,    0, 16'h3333, 1, 16'h0777, LEDX,  1};

        sw = 16'h0;
        set_idle();
        do_reset();

        for (int i = 0; i < 16; i++) begin
            pc_rd = vt[i].pc_rd; pc_addr = vt[i].pc_a;
            ld_rd = vt[i].ld_rd; ld_wr = vt[i].ld_wr;
            ld_addr = vt[i].ld_a; ld_wd = vt[i].wd; sw = vt[i].sw;
            step();
            chk("vec_pc_v", {15'h0, pc_v1}, {15'h0, vt[i].e_pcv});
            chk("vec_pc_d", pc_d1, vt[i].e_pcd);
            chk("vec_ld_v", {15'h0, ld_v1}, {15'h0, vt[i].e_ldv});
            chk("vec_ld_d", ld_d1, vt[i].e_ldd);
            chk("vec_led", led1, vt[i].e_led);
            chk("vec_err", {15'h0, err1}, {15'h0, vt[i].e_err});
        end
        set_idle();
        step();

        // Reset one cycle after a latency-2 fetch: the result never appears.
        do_reset();
        pc_rd = 1'b1; pc_addr = 16'h0010;
        step();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_pulse", {15'h0, pc_v2}, 16'h0);
        end
        pc_rd = 1'b1; pc_addr = 16'h0010; ld_rd = 1'b1; ld_addr = 16'h0020;
        step();
        set_idle();
        step();
        chk("rst_ram_keep_pc", pc_d2, 16'h1234);
        chk("rst_ram_keep_ld", ld_d2, 16'hBEEF);

        // Each error source on its own, from a clean flag.
        do_reset();
        ld_wr = 1'b1; ld_addr = 16'h0011; ld_wd = 16'h5555;
        step();
        chk("err_misaligned_wr", {15'h0, err1}, 16'h1);
        do_reset();
        ld_rd = 1'b1; ld_addr = 16'(2 * DEPTH);
        step();
        chk("err_oor_rd_data", ld_d1, 16'h0);
        chk("err_oor_rd", {15'h0, err1}, 16'h1);
        do_reset();
        ld_rd = 1'b1; ld_wr = 1'b1; ld_addr = 16'h0040; ld_wd = 16'h0ABC;
        step();
        chk("err_rdwr_novalid", {15'h0, ld_v1}, 16'h0);
        chk("err_rdwr", {15'h0, err1}, 16'h1);
        set_idle();
        ld_rd = 1'b1; ld_addr = 16'h0040;
        step();
        chk("rdwr_write_landed", ld_d1, 16'h0ABC);
        do_reset();
        pc_rd = 1'b1; pc_addr = 16'hF000;
        step();
        chk("err_pc_mmio", {15'h0, err1}, 16'h1);

        // Fill the whole RAM so random reads have known contents.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ld_wr = 1'b1; ld_rd = 1'b0; ld_addr = 16'(2 * i);
            ld_wd = 16'($urandom);
            pc_rd = 1'b1; pc_addr = 16'(2 * $urandom_range(0, DEPTH - 1));
            step();
        end

        // Random traffic with occasional mid-flight resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            pc_rd   = ($urandom_range(0, 3) != 0);
            pc_addr = rand_addr(1'b1);
            ld_wr   = ($urandom_range(0, 2) == 0);
            ld_rd   = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) != 0 && ld_wr) ld_rd = 1'b0;
            ld_addr = rand_addr(1'b1);
            ld_wd   = 16'($urandom);
            sw      = 16'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
